// File: rtl/pv_vd_fifo.sv
// rtl/pv_vd_fifo.sv - Vd sample FIFO between network solver and PV cell model
// Optional empty-cycle write-to-read bypass enabled by defining PV_VD_FIFO_BYPASS_EN.
module pv_vd_fifo #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;
    logic              rd_valid_d, rd_valid_q;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              full_w, empty_w;
    logic              wr_acc, rd_acc, bypass;

    // Flags decode only from registered occupancy, never from the strobes.
    assign full_w  = (count_q == FULL_CNT);
    assign empty_w = (count_q == '0);

    always_comb begin
        bypass      = 1'b0;
        rd_acc      = rd_en && !empty_w;
        wr_acc      = wr_en && (!full_w || rd_en);
        overflow_d  = overflow_q  || (wr_en && full_w && !rd_en);
        underflow_d = underflow_q || (rd_en && empty_w);
`ifdef PV_VD_FIFO_BYPASS_EN
        if (empty_w && rd_en && wr_en) begin
            bypass      = 1'b1;
            wr_acc      = 1'b0;
            underflow_d = underflow_q;
        end
`endif
        wr_ptr_d   = wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d   = rd_acc ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        rd_valid_d = rd_acc || bypass;
        rd_data_d  = rd_data_q;
        if (bypass)
            rd_data_d = wr_data;
        else if (rd_acc)
            rd_data_d = mem[rd_ptr_q];
        count_d = count_q;
        if (wr_acc && !rd_acc)
            count_d = count_q + (ADDR_W+1)'(1);
        else if (rd_acc && !wr_acc)
            count_d = count_q - (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (rst && !flush && wr_acc)
            mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
